imem_loader: RTL and testbench

Write-side companion to the instruction memory: receives a byte stream over a valid/ready handshake, packs each pair of bytes into one 15-bit instruction word, and drives the instruction memory's write port with sequential addresses. It sits between the host/boot byte source and the instruction memory, and holds the CPU off while a program is being loaded.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 15
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a low-byte-first byte stream into instruction words and writes them to
// sequential instruction-memory addresses; busy holds the CPU off meanwhile.
//
// state   | meaning
// IDLE    | waiting for start, CPU released
// LO      | waiting for low byte of the current word
// HI      | waiting for high byte of the current word
// WRITE   | mem_we asserted for the assembled word
// DONE    | one-cycle done pulse after the last write
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WRITE,
    S_DONE
  } state_t;

  // high-byte bits that do not fit in the word; all zero when WORD_W is 16
  localparam logic [7:0]        HI_MASK  = 8'hFF << (WORD_W - 8);
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining;
  logic [WORD_W-1:0] word_q;
  logic              error_q;
  logic              accept;

  assign accept = bus.in_ready & bus.in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LO;
      S_LO: begin
        if (abort)             state_nxt = S_IDLE;
        else if (bus.in_valid) state_nxt = S_HI;
      end
      S_HI: begin
        if (abort)             state_nxt = S_IDLE;
        else if (bus.in_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (abort)                     state_nxt = S_IDLE;
        else if (remaining == CNT_ONE) state_nxt = S_DONE;
        else                           state_nxt = S_LO;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_LO, S_HI: begin
        bus.in_ready = ~abort;
        busy         = 1'b1;
      end
      S_WRITE: begin
        bus.mem_we = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word_q;
  assign error         = error_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      remaining <= '0;
      word_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q    <= start_addr;
            remaining <= (word_count == '0) ? CNT_FULL : {1'b0, word_count};
            error_q   <= 1'b0;
          end
        end
        S_LO: begin
          if (accept) word_q[7:0] <= bus.in_data;
        end
        S_HI: begin
          if (accept) begin
            word_q[WORD_W-1:8] <= bus.in_data[WORD_W-9:0];
            if ((bus.in_data & HI_MASK) != 8'h00) error_q <= 1'b1;
          end
        end
        S_WRITE: begin
          addr_q    <= addr_q + ADDR_W'(1);
          remaining <= remaining - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: writes are scoreboarded against words
// computed directly from the byte stream, start address and count.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int WORD_W = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] word_count = '0;
  logic              busy, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .word_count(word_count),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [WORD_W-1:0] wr_data[$];
  int                wr_cyc[$];
  int                acc_cyc[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  logic              done_busy = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    acc_cyc.delete();
    done_cnt  = 0;
    done_busy = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] cnt, input string tag);
    start_addr = a;
    word_count = cnt;
    start      = 1'b1;
    step();
    start      = 1'b0;
    @(negedge clk);
    chk({tag, ":busy_after_start"}, 32'(busy), 1);
    chk({tag, ":ready_after_start"}, 32'(bus.in_ready), 1);
    chk({tag, ":error_cleared"}, 32'(error), 0);
    step();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc = 1'b0;
    if (gaps) begin
      int g = $urandom_range(0, 3);
      bus.in_valid = 1'b0;
      repeat (g) step();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    if (gaps) bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && done_cnt == 0; k++) @(negedge clk);
    step();
  endtask

  task automatic expect_load(input logic [7:0] a, input logic [7:0] cnt,
                             input logic [7:0] bytes[$], input string tag);
    int nw = (cnt == 8'd0) ? 256 : int'(cnt);
    bit exp_err = 1'b0;
    chk({tag, ":num_writes"}, 32'(wr_addr.size()), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      logic [7:0] lo = bytes[2*i];
      logic [7:0] hi = bytes[2*i+1];
      if (hi >= 8'd128) exp_err = 1'b1;
      if (i < wr_addr.size()) begin
        chk({tag, ":addr"}, 32'(wr_addr[i]), 32'((int'(a) + i) % 256));
        chk({tag, ":data"}, 32'(wr_data[i]), 32'(int'(hi % 8'd128) * 256 + int'(lo)));
      end
    end
    chk({tag, ":done_count"}, 32'(done_cnt), 1);
    chk({tag, ":error"}, 32'(error), 32'(exp_err));
    chk({tag, ":busy_at_done"}, 32'(done_busy), 0);
    if (wr_cyc.size() > 0)
      chk({tag, ":done_latency"}, 32'(done_cyc), 32'(wr_cyc[wr_cyc.size()-1] + 1));
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] cnt,
                         input logic [7:0] bytes[$], input bit gaps, input string tag);
    clear_mon();
    pulse_start(a, cnt, tag);
    foreach (bytes[i]) send_byte(bytes[i], gaps);
    bus.in_valid = 1'b0;
    wait_done();
    expect_load(a, cnt, bytes, tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, ":mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, ":mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, ":mem_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, ":busy"}, 32'(busy), 0);
    chk({tag, ":done"}, 32'(done), 0);
    chk({tag, ":error"}, 32'(error), 0);
  endtask

  initial begin
    logic [7:0] bq[$];
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // reset with start and in_valid held high
    rst_n = 1'b0; start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hAB;
    repeat (3) step();
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset:no_writes", 32'(wr_addr.size()), 0);
    step();
    start = 1'b0; bus.in_valid = 1'b0; rst_n = 1'b1;
    step();

    // basic load, continuous stream
    bq = {8'h34, 8'h12, 8'hCD, 8'h7A};
    do_load(8'h10, 8'd2, bq, 1'b0, "basic");
    if (acc_cyc.size() > 0 && wr_cyc.size() == 2)
      chk("basic:accept_to_last_write", 32'(wr_cyc[1] - acc_cyc[0]), 5);
    else
      chk("basic:trace_shape", 32'(wr_cyc.size()), 2);

    // format error with stalls, sticky into idle
    bq = {8'h55, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04};
    do_load(8'h30, 8'd3, bq, 1'b1, "fmt_err");
    repeat (3) step();
    chk("fmt_err:sticky_idle", 32'(error), 1);

    // wrap with zero count (256 words)
    bq.delete();
    for (int i = 0; i < 512; i++) bq.push_back(8'($urandom));
    do_load(8'hFF, 8'd0, bq, 1'b0, "wrap");

    // abort in HI after the low byte
    clear_mon();
    pulse_start(8'h20, 8'd3, "abort_hi");
    send_byte(8'h11, 1'b0);
    abort = 1'b1;
    bus.in_data = 8'h22;
    @(negedge clk);
    chk("abort_hi:ready_low", 32'(bus.in_ready), 0);
    step();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_hi:busy_next", 32'(busy), 0);
    repeat (3) step();
    chk("abort_hi:no_write", 32'(wr_addr.size()), 0);
    chk("abort_hi:no_done", 32'(done_cnt), 0);
    bq = {8'hA5, 8'h5A};
    do_load(8'h21, 8'd1, bq, 1'b0, "after_abort");

    // abort during WRITE: that write still happens
    clear_mon();
    pulse_start(8'h60, 8'd3, "abort_wr");
    send_byte(8'h0F, 1'b0);
    send_byte(8'h70, 1'b0);
    abort = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_wr:mem_we", 32'(bus.mem_we), 1);
    step();
    abort = 1'b0;
    repeat (3) step();
    chk("abort_wr:one_write", 32'(wr_addr.size()), 1);
    if (wr_data.size() > 0) chk("abort_wr:data", 32'(wr_data[0]), 32'h700F);
    chk("abort_wr:no_done", 32'(done_cnt), 0);
    chk("abort_wr:busy", 32'(busy), 0);

    // start pulsed while busy is ignored
    clear_mon();
    bq = {8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start(8'h40, 8'd2, "start_busy");
    start_addr = 8'h99; word_count = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    foreach (bq[i]) send_byte(bq[i], 1'b0);
    bus.in_valid = 1'b0;
    wait_done();
    expect_load(8'h40, 8'd2, bq, "start_busy");

    // reset while in HI
    clear_mon();
    pulse_start(8'h50, 8'd2, "rst_mid");
    send_byte(8'h77, 1'b0);
    bus.in_data = 8'h33;
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("rst_mid:no_write", 32'(wr_addr.size()), 0);

    // random loads
    for (int t = 0; t < 8; t++) begin
      logic [7:0] a   = 8'($urandom);
      logic [7:0] cnt = 8'($urandom_range(1, 8));
      bq.delete();
      for (int i = 0; i < 2 * int'(cnt); i++) bq.push_back(8'($urandom));
      do_load(a, cnt, bq, 1'($urandom_range(0, 1)), "random");
      repeat ($urandom_range(0, 2)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
